// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 decode constants, field encodings and e_control layout
package lc3_pkg;

   // Opcodes (IR[15:12])
   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RES  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_AND = 2'b01,
      ALU_NOT = 2'b10
   } alu_sel_t;

   typedef enum logic [1:0] {
      PCSEL1_OFF11 = 2'b00,
      PCSEL1_OFF9  = 2'b01,
      PCSEL1_OFF6  = 2'b10,
      PCSEL1_ZERO  = 2'b11
   } pcsel1_t;

   typedef enum logic [1:0] {
      WSEL_ALU = 2'b00,
      WSEL_MEM = 2'b01,
      WSEL_PC  = 2'b10
   } wsel_t;

   // Bubble: BR with nzp=000 never branches
   localparam logic [15:0] NOP_IR = 16'h0000;

   // e_control = {alu[1:0], pcselect1[1:0], pcselect2, op2select}
   localparam int EC_ALU_HI  = 5;
   localparam int EC_ALU_LO  = 4;
   localparam int EC_PCS1_HI = 3;
   localparam int EC_PCS1_LO = 2;
   localparam int EC_PCS2    = 1;
   localparam int EC_OP2     = 0;

endpackage

// File: rtl/lc3_ctrl_decode.sv
// rtl/lc3_ctrl_decode.sv - combinational opcode to control-field decoder
// Ports:
//   opcode      in  4  IR[15:12]
//   imm_sel     in  1  IR[5] (1 = imm5 operand for ADD/AND)
//   e_control   out 6  {alu, pcselect1, pcselect2, op2select}
//   w_control   out 2  writeback source
//   mem_control out 1  indirect access
//   illegal     out 1  opcode not supported by this core
module lc3_ctrl_decode
   import lc3_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       imm_sel,
   output logic [5:0] e_control,
   output logic [1:0] w_control,
   output logic       mem_control,
   output logic       illegal
);

   alu_sel_t alu;
   pcsel1_t  pcs1;
   wsel_t    wsel;
   logic     pcs2;
   logic     op2;

   always_comb begin
      alu         = ALU_ADD;
      pcs1        = PCSEL1_OFF11;
      wsel        = WSEL_ALU;
      pcs2        = 1'b0;
      op2         = 1'b0;
      mem_control = 1'b0;
      illegal     = 1'b0;
      case (opcode)
         OP_ADD: begin alu = ALU_ADD; op2 = ~imm_sel; end
         OP_AND: begin alu = ALU_AND; op2 = ~imm_sel; end
         OP_NOT: alu = ALU_NOT;
         OP_BR:  begin pcs1 = PCSEL1_OFF9; pcs2 = 1'b1; end
         OP_JMP: pcs1 = PCSEL1_ZERO;
         OP_LD:  begin pcs1 = PCSEL1_OFF9; pcs2 = 1'b1; wsel = WSEL_MEM; end
         OP_ST:  begin pcs1 = PCSEL1_OFF9; pcs2 = 1'b1; end
         OP_LDI: begin pcs1 = PCSEL1_OFF9; pcs2 = 1'b1; wsel = WSEL_MEM; mem_control = 1'b1; end
         OP_STI: begin pcs1 = PCSEL1_OFF9; pcs2 = 1'b1; mem_control = 1'b1; end
         OP_LEA: begin pcs1 = PCSEL1_OFF9; pcs2 = 1'b1; wsel = WSEL_PC; end
         OP_LDR: begin pcs1 = PCSEL1_OFF6; wsel = WSEL_MEM; end
         OP_STR: pcs1 = PCSEL1_OFF6;
         default: illegal = 1'b1;   // JSR, RTI, reserved, TRAP
      endcase
      e_control                       = '0;
      e_control[EC_ALU_HI:EC_ALU_LO]   = alu;
      e_control[EC_PCS1_HI:EC_PCS1_LO] = pcs1;
      e_control[EC_PCS2]              = pcs2;
      e_control[EC_OP2]               = op2;
      w_control                       = wsel;
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - LC-3 decode pipeline stage with stall, flush and illegal-opcode flag
// Ports:
//   clock, reset (sync active-low)
//   enable_decode  capture new instruction, else hold
//   flush          replace contents with bubble (npc_out held)
//   dout, npc_in   instruction word and next-PC from fetch
//   ir, npc_out, e_control, w_control, mem_control, valid_out, illegal_op  registered outputs
module decode_stage
   import lc3_pkg::*;
#(
   parameter int              DATA_W = 16,
   parameter logic [DATA_W-1:0] NOP_IR = lc3_pkg::NOP_IR
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable_decode,
   input  logic              flush,
   input  logic [DATA_W-1:0] dout,
   input  logic [DATA_W-1:0] npc_in,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] npc_out,
   output logic [5:0]        e_control,
   output logic [1:0]        w_control,
   output logic              mem_control,
   output logic              valid_out,
   output logic              illegal_op
);

   logic [5:0] dec_e;
   logic [1:0] dec_w;
   logic       dec_mem;
   logic       dec_illegal;

   lc3_ctrl_decode u_dec (
      .opcode      (dout[15:12]),
      .imm_sel     (dout[5]),
      .e_control   (dec_e),
      .w_control   (dec_w),
      .mem_control (dec_mem),
      .illegal     (dec_illegal)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         ir          <= NOP_IR;
         npc_out     <= '0;
         e_control   <= '0;
         w_control   <= '0;
         mem_control <= 1'b0;
         valid_out   <= 1'b0;
         illegal_op  <= 1'b0;
      end else if (flush) begin
         // Bubble; npc_out deliberately kept, illegal_op untouched
         ir          <= NOP_IR;
         e_control   <= '0;
         w_control   <= '0;
         mem_control <= 1'b0;
         valid_out   <= 1'b0;
      end else if (enable_decode) begin
         npc_out     <= npc_in;
         // Decoder already drives zero controls for illegal opcodes
         e_control   <= dec_e;
         w_control   <= dec_w;
         mem_control <= dec_mem;
         if (dec_illegal) begin
            ir         <= NOP_IR;
            valid_out  <= 1'b0;
            illegal_op <= 1'b1;
         end else begin
            ir         <= dout;
            valid_out  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable_decode = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] dout = 16'h0000;
   logic [15:0] npc_in = 16'h0000;
   logic [15:0] ir;
   logic [15:0] npc_out;
   logic [5:0]  e_control;
   logic [1:0]  w_control;
   logic        mem_control;
   logic        valid_out;
   logic        illegal_op;

   int n_cmp = 0;
   int n_bad = 0;

   decode_stage dut (
      .clock         (clock),
      .reset         (reset),
      .enable_decode (enable_decode),
      .flush         (flush),
      .dout          (dout),
      .npc_in        (npc_in),
      .ir            (ir),
      .npc_out       (npc_out),
      .e_control     (e_control),
      .w_control     (w_control),
      .mem_control   (mem_control),
      .valid_out     (valid_out),
      .illegal_op    (illegal_op)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0; enable_decode = 1'b1;
      dout = 16'h1283; npc_in = 16'h3001;
      step();
      n_cmp++;
      if ({ir, npc_out, e_control, w_control, mem_control, valid_out, illegal_op} !== 43'd0) begin
         n_bad++;
         $display("FAIL reset: ir=%h npc=%h e=%b w=%b m=%b v=%b ill=%b, want all zero",
                  ir, npc_out, e_control, w_control, mem_control, valid_out, illegal_op);
      end
      reset = 1'b1;
   endtask

   task automatic test_add();
      enable_decode = 1'b1; dout = 16'h1283; npc_in = 16'h3001;
      step();
      n_cmp++;
      if (ir !== 16'h1283 || npc_out !== 16'h3001 || e_control !== 6'b000001 ||
          w_control !== 2'b00 || mem_control !== 1'b0 || valid_out !== 1'b1) begin
         n_bad++;
         $display("FAIL add: ir=%h npc=%h e=%b w=%b m=%b v=%b, want 1283 3001 000001 00 0 1",
                  ir, npc_out, e_control, w_control, mem_control, valid_out);
      end
   endtask

   task automatic test_decode_table();
      logic [15:0] vin [8];
      logic [5:0]  ve  [8];
      logic [1:0]  vw  [8];
      logic        vm  [8];
      vin[0] = 16'h6942; ve[0] = 6'b001000; vw[0] = 2'b01; vm[0] = 1'b0; // LDR
      vin[1] = 16'hA005; ve[1] = 6'b000110; vw[1] = 2'b01; vm[1] = 1'b1; // LDI
      vin[2] = 16'h5061; ve[2] = 6'b010000; vw[2] = 2'b00; vm[2] = 1'b0; // AND imm
      vin[3] = 16'h927F; ve[3] = 6'b100000; vw[3] = 2'b00; vm[3] = 1'b0; // NOT
      vin[4] = 16'h0E02; ve[4] = 6'b000110; vw[4] = 2'b00; vm[4] = 1'b0; // BR
      vin[5] = 16'hC1C0; ve[5] = 6'b001100; vw[5] = 2'b00; vm[5] = 1'b0; // JMP
      vin[6] = 16'hB201; ve[6] = 6'b000110; vw[6] = 2'b00; vm[6] = 1'b1; // STI
      vin[7] = 16'h2403; ve[7] = 6'b000110; vw[7] = 2'b01; vm[7] = 1'b0; // LD
      for (int i = 0; i < 8; i++) begin
         enable_decode = 1'b1; dout = vin[i]; npc_in = 16'h4000 + 16'(i);
         step();
         n_cmp++;
         if (ir !== vin[i] || npc_out !== 16'h4000 + 16'(i) || e_control !== ve[i] ||
             w_control !== vw[i] || mem_control !== vm[i] || valid_out !== 1'b1) begin
            n_bad++;
            $display("FAIL decode[%0d]: ir=%h npc=%h e=%b w=%b m=%b v=%b, want %h %h %b %b %b 1",
                     i, ir, npc_out, e_control, w_control, mem_control, valid_out,
                     vin[i], 16'h4000 + 16'(i), ve[i], vw[i], vm[i]);
         end
      end
   endtask

   task automatic test_stall_flush();
      enable_decode = 1'b1; dout = 16'hE605; npc_in = 16'h3010;
      step();
      n_cmp++;
      if (ir !== 16'hE605 || e_control !== 6'b000110 || w_control !== 2'b10 || valid_out !== 1'b1) begin
         n_bad++;
         $display("FAIL lea: ir=%h e=%b w=%b v=%b, want e605 000110 10 1", ir, e_control, w_control, valid_out);
      end
      enable_decode = 1'b0;
      for (int i = 0; i < 3; i++) begin
         dout = 16'h1000 + 16'(i); npc_in = 16'h5000 + 16'(i);
         step();
         n_cmp++;
         if (ir !== 16'hE605 || npc_out !== 16'h3010 || e_control !== 6'b000110 ||
             w_control !== 2'b10 || valid_out !== 1'b1) begin
            n_bad++;
            $display("FAIL stall[%0d]: ir=%h npc=%h e=%b w=%b v=%b, want e605 3010 000110 10 1",
                     i, ir, npc_out, e_control, w_control, valid_out);
         end
      end
      flush = 1'b1; enable_decode = 1'b1; dout = 16'h1283; npc_in = 16'h7777;
      step();
      flush = 1'b0;
      n_cmp++;
      if (ir !== 16'h0000 || valid_out !== 1'b0 || npc_out !== 16'h3010 ||
          e_control !== 6'd0 || w_control !== 2'd0 || mem_control !== 1'b0) begin
         n_bad++;
         $display("FAIL flush: ir=%h v=%b npc=%h e=%b w=%b m=%b, want 0000 0 3010 0 0 0",
                  ir, valid_out, npc_out, e_control, w_control, mem_control);
      end
   endtask

   task automatic test_npc_wrap();
      enable_decode = 1'b1; dout = 16'h1283; npc_in = 16'hFFFF;
      step();
      n_cmp++;
      if (npc_out !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL npc_wrap: npc=%h want ffff", npc_out);
      end
   endtask

   task automatic test_illegal();
      enable_decode = 1'b1; dout = 16'hF025; npc_in = 16'h3100;
      step();
      n_cmp++;
      if (ir !== 16'h0000 || valid_out !== 1'b0 || illegal_op !== 1'b1 ||
          e_control !== 6'd0 || w_control !== 2'd0 || mem_control !== 1'b0) begin
         n_bad++;
         $display("FAIL trap: ir=%h v=%b ill=%b e=%b w=%b m=%b, want 0000 0 1 0 0 0",
                  ir, valid_out, illegal_op, e_control, w_control, mem_control);
      end
      dout = 16'h1283; npc_in = 16'h3101;
      step();
      n_cmp++;
      if (ir !== 16'h1283 || valid_out !== 1'b1 || illegal_op !== 1'b1) begin
         n_bad++;
         $display("FAIL sticky: ir=%h v=%b ill=%b, want 1283 1 1", ir, valid_out, illegal_op);
      end
   endtask

   task automatic test_simultaneous();
      reset = 1'b0; flush = 1'b1; enable_decode = 1'b1; dout = 16'h1283; npc_in = 16'h2222;
      step();
      n_cmp++;
      if ({ir, npc_out, e_control, w_control, mem_control, valid_out, illegal_op} !== 43'd0) begin
         n_bad++;
         $display("FAIL reset_prio: ir=%h npc=%h e=%b w=%b m=%b v=%b ill=%b, want all zero",
                  ir, npc_out, e_control, w_control, mem_control, valid_out, illegal_op);
      end
      reset = 1'b1; flush = 1'b1; dout = 16'hD000; npc_in = 16'h2223;
      step();
      flush = 1'b0;
      n_cmp++;
      if (ir !== 16'h0000 || valid_out !== 1'b0 || illegal_op !== 1'b0 || npc_out !== 16'h0000) begin
         n_bad++;
         $display("FAIL flush_illegal: ir=%h v=%b ill=%b npc=%h, want 0000 0 0 0000",
                  ir, valid_out, illegal_op, npc_out);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_decode_table();
      test_stall_flush();
      test_npc_wrap();
      test_illegal();
      test_simultaneous();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of instruction fetch in the LC-3 in-order core.
- Captures the instruction word returned by instruction memory and the fetch-supplied next-PC into pipeline registers.
- Produces registered execute, writeback and memory control fields for the Execute stage.
- Supports stall (hold), flush (bubble insertion), a valid bit, and a sticky illegal-opcode flag.

Parameters:
- DATA_W, 16, instruction/address width.
- NOP_IR, 16'h0000, bubble instruction (BR with nzp=000).

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset; registers clear on the clock edge where reset==0
- enable_decode  in  1  1=capture new instruction; 0=hold all outputs
- flush  in  1  branch-taken/redirect from execute; replace stage contents with bubble
- dout  in  DATA_W  instruction word from instruction memory, valid when enable_decode=1
- npc_in  in  DATA_W  next-PC from fetch (PC+1 of the instruction in dout)
- ir  out  DATA_W  registered instruction
- npc_out  out  DATA_W  registered next-PC
- e_control  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- w_control  out  2  writeback source select
- mem_control  out  1  1=indirect access (LDI/STI)
- valid_out  out  1  1=ir holds a real instruction
- illegal_op  out  1  sticky; set on decode of an unsupported opcode

Behaviour:
- Reset (reset==0 at the clock edge):
  - ir=NOP_IR, npc_out=0, e_control=0, w_control=0, mem_control=0, valid_out=0, illegal_op=0.
  - Reset has priority over flush and enable.
- Priority per edge: reset > flush > enable_decode > hold.
- Flush: load the bubble state. ir=NOP_IR, control fields=0, valid_out=0, npc_out held.
- Capture (enable_decode=1, no flush):
  - ir<=dout, npc_out<=npc_in, valid_out<=1.
  - Control fields <= decode(dout).
  - Latency: exactly one cycle from dout to outputs.
- Hold (enable_decode=0, no flush): every output register keeps its value, including across multiple stall cycles.
- Decode of IR[15:12]:
  - ADD 0001: alu=00, w=00.
  - AND 0101: alu=01, w=00.
  - NOT 1001: alu=10, w=00, op2select=0.
  - ADD/AND: op2select = ~IR[5] (1=register operand, 0=imm5).
  - BR 0000: pcselect1=01 (sext IR[8:0]), pcselect2=1 (npc base).
  - JMP 1100: pcselect1=11 (zero), pcselect2=0 (base register).
  - LD 0010, ST 0011, LDI 1010, STI 1011, LEA 1110: pcselect1=01, pcselect2=1.
  - LDR 0110, STR 0111: pcselect1=10 (sext IR[5:0]), pcselect2=0.
  - Loads LD/LDR/LDI: w=01 (memory).
  - LEA: w=10 (PC-relative).
  - mem_control=1 for LDI and STI only.
  - All unlisted fields are 0.
- Illegal opcodes 0100 (JSR), 1000 (RTI), 1101, 1111 (TRAP):
  - Captured as NOP: ir=NOP_IR, controls=0, valid_out=0.
  - illegal_op<=1 and stays 1 until reset.
  - A flush in the same cycle suppresses setting illegal_op.
- npc_out is a pure register of npc_in; no arithmetic, so wrap at 16'hFFFF is preserved as given.

Decomposition:
- Shared package lc3_pkg holds:
  - Opcode constants.
  - Field enums ALU_ADD/AND/NOT, PCSEL1_OFF11/OFF9/OFF6/ZERO, WSEL_ALU/MEM/PC.
  - NOP_IR.
  - e_control bit-position constants.
- One combinational sub-module, lc3_ctrl_decode: maps an instruction to {e_control, w_control, mem_control, illegal}.
- decode_stage owns the pipeline registers and the priority logic.

Test Plan:
- Reset: drive reset=0 with flush=0 and enable_decode=1, dout=16'h1283 -> next cycle ir=16'h0000, valid_out=0, illegal_op=0, all controls 0.
- ADD R1,R2,R3: dout=16'h1283, npc_in=16'h3001, enable=1 -> ir=16'h1283, npc_out=16'h3001, e_control=6'b000001, w_control=00, valid_out=1.
- LDR and LDI: dout=16'h6942 -> e_control=6'b001000, w_control=01, mem_control=0; then dout=16'hA005 -> e_control=6'b000110, mem_control=1, w_control=01.
- Stall then flush: capture 16'hE605 (LEA, w_control=10), then enable=0 for 3 cycles while dout changes -> outputs unchanged; then flush=1 with enable=1 -> ir=16'h0000, valid_out=0, npc_out unchanged.
- Illegal opcode: dout=16'hF025 (TRAP) -> ir=16'h0000, valid_out=0, illegal_op=1; a later ADD leaves illegal_op=1 until reset=0.
- Simultaneous events: reset=0 with flush=1 and enable=1 -> reset state; flush=1 with dout=16'hD000 -> bubble, illegal_op stays 0.
